// File: rtl/axis_hdr_insert_pipe_pkg.sv
// Shared state type and byte-enable helpers for the AXI-Stream header inserter.
package axis_hdr_pkg;
  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  function automatic logic [MAX_BYTES-1:0] keep_msb_mask(input int unsigned n,
                                                         input int unsigned nbytes);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++)
      if (i < nbytes && i + n >= nbytes) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_BYTES-1:0] keep);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (keep[i]) c++;
    return c;
  endfunction

  function automatic logic hdr_keep_ok(input logic [MAX_BYTES-1:0] keep,
                                       input int unsigned cnt);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < MAX_BYTES; i++)
      if (keep[i] != (i < cnt)) ok = 1'b0;
    return ok;
  endfunction
endpackage

// File: rtl/axis_hdr_insert_pipe_if.sv
// Input stream, output stream and header channel of the header inserter.
interface axis_hdr_insert_pipe_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                    valid_in;
  logic                    ready_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    valid_out;
  logic                    ready_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    valid_insert;
  logic                    ready_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic [BYTE_CNT_WD:0]    byte_insert_cnt;
  logic                    hdr_err;

  modport slave (
    input  valid_in, data_in, keep_in, last_in, ready_out,
           valid_insert, data_insert, keep_insert, byte_insert_cnt,
    output ready_in, valid_out, data_out, keep_out, last_out, ready_insert, hdr_err
  );

  modport master (
    output valid_in, data_in, keep_in, last_in, ready_out,
           valid_insert, data_insert, keep_insert, byte_insert_cnt,
    input  ready_in, valid_out, data_out, keep_out, last_out, ready_insert, hdr_err
  );
endinterface

// File: rtl/axis_hdr_insert_pipe_byte_merge.sv
// Combinational realignment: carry bytes followed by the leading bytes of the new beat.
module axis_byte_merge
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic [DATA_WD-1:0]      carry,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic [BYTE_CNT_WD:0]    h,
  output logic [DATA_WD-1:0]      beat,
  output logic [DATA_WD-1:0]      carry_nxt,
  output logic [BYTE_CNT_WD+1:0]  t
);
  localparam int TW = BYTE_CNT_WD + 2;

  // only the low h bytes of carry survive the shift, so stale upper bytes never leak
  assign beat      = DATA_WD'({carry, data_in} >> {h, 3'b000});
  assign carry_nxt = data_in;
  assign t         = TW'(h) + TW'(popcount(MAX_BYTES'(keep_in)));
endmodule

// File: rtl/axis_hdr_insert_pipe.sv
// Back-pressured AXI-Stream header inserter: FSM, carry register and one output register.
module axis_hdr_insert_pipe
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input logic                  clk,
  input logic                  rst,
  axis_hdr_insert_pipe_if.slave bus
);
  localparam int CW = BYTE_CNT_WD + 1;
  localparam int TW = BYTE_CNT_WD + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_BYTE_WD);
  localparam logic [TW-1:0] FULL_T   = TW'(DATA_BYTE_WD);

  function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] cnt);
    return (cnt > FULL_CNT) ? FULL_CNT : cnt;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] top_keep(input logic [TW-1:0] n);
    return DATA_BYTE_WD'(keep_msb_mask(32'(n), DATA_BYTE_WD));
  endfunction

  state_t                  state_p0, state_d;
  logic [DATA_WD-1:0]      carry_p0;
  logic [CW-1:0]           h_p0;
  logic [TW-1:0]           t_p0;
  logic                    vld_p1, last_p1, hdr_err_p1;
  logic [DATA_WD-1:0]      data_p1;
  logic [DATA_BYTE_WD-1:0] keep_p1;

  logic [DATA_WD-1:0]      beat, carry_nxt, flush_beat, data_d;
  logic [TW-1:0]           t;
  logic [DATA_BYTE_WD-1:0] keep_d, flush_keep;
  logic                    last_d, load, in_hs, hdr_hs, hdr_bad, slot_free, in_rdy, hdr_rdy;

  axis_byte_merge #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_merge (
    .carry     (carry_p0),
    .data_in   (bus.data_in),
    .keep_in   (bus.keep_in),
    .h         (h_p0),
    .beat      (beat),
    .carry_nxt (carry_nxt),
    .t         (t)
  );

  assign slot_free  = !vld_p1 || bus.ready_out;
  assign flush_beat = DATA_WD'({carry_p0, {DATA_WD{1'b0}}} >> {h_p0, 3'b000});
  assign flush_keep = top_keep(t_p0 - FULL_T);
  assign hdr_bad    = (bus.byte_insert_cnt > FULL_CNT) ||
                      !hdr_keep_ok(MAX_BYTES'(bus.keep_insert), 32'(bus.byte_insert_cnt));

  always_comb begin
    state_d = state_p0;
    in_rdy  = 1'b0;
    hdr_rdy = 1'b0;
    hdr_hs  = 1'b0;
    in_hs   = 1'b0;
    load    = 1'b0;
    data_d  = '0;
    keep_d  = '0;
    last_d  = 1'b0;
    case (state_p0)
      IDLE: begin
        hdr_rdy = 1'b1;
        if (bus.valid_insert) begin
          hdr_hs  = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        in_rdy = slot_free;
        if (bus.valid_in && slot_free) begin
          in_hs  = 1'b1;
          load   = 1'b1;
          data_d = beat;
          keep_d = '1;
          if (bus.last_in) begin
            if (t <= FULL_T) begin
              keep_d  = top_keep(t);
              data_d  = beat & byte_mask(keep_d);
              last_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          load    = 1'b1;
          keep_d  = flush_keep;
          data_d  = flush_beat & byte_mask(flush_keep);
          last_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= IDLE;
      carry_p0   <= '0;
      h_p0       <= '0;
      t_p0       <= '0;
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      keep_p1    <= '0;
      last_p1    <= 1'b0;
      hdr_err_p1 <= 1'b0;
    end else begin
      state_p0   <= state_d;
      hdr_err_p1 <= hdr_hs && hdr_bad;
      // stage p0: header / carry state feeding the realignment
      if (hdr_hs) begin
        carry_p0 <= bus.data_insert;
        h_p0     <= sat_cnt(bus.byte_insert_cnt);
      end
      if (in_hs) begin
        carry_p0 <= carry_nxt;
        t_p0     <= t;
      end
      // stage p1: the single output register
      if (load) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_d;
        keep_p1 <= keep_d;
        last_p1 <= last_d;
      end else if (bus.ready_out) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.ready_in     = in_rdy;
  assign bus.ready_insert = hdr_rdy;
  assign bus.valid_out    = vld_p1;
  assign bus.data_out     = data_p1;
  assign bus.keep_out     = keep_p1;
  assign bus.last_out     = last_p1;
  assign bus.hdr_err      = hdr_err_p1;
endmodule
